// File: rtl/conv3x3_filter.sv
// conv3x3_filter
// Pipelined 3x3 convolution stage placed after the window fetch memory.
// Each valid window is multiplied by a signed 8-bit kernel, summed,
// arithmetically right-shifted and saturated to an unsigned 8-bit pixel,
// which is written to the result memory through pixelw/wr. A frame
// counter tracks IMG_W*IMG_H accepted windows, so the block also reports
// frame completion.
//
// State table:
//   IDLE  | waiting for start; in_valid ignored
//   RUN   | accepting windows, counting them toward IMG_W*IMG_H
//   DRAIN | frame fully accepted; waiting for the pipeline to empty
//   DONE  | frame complete; done=1 until the next start
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   start               one-cycle pulse; arms a frame from IDLE or DONE
//   in_valid            window on pixelr1..pixelr9 is valid this cycle
//   pixelr1..pixelr9    unsigned window pixels, row-major, top-left first
//   pixelw              filtered pixel (0 whenever wr=0)
//   wr                  write strobe for pixelw
//   busy                high in RUN and DRAIN
//   done                high in DONE
module conv3x3_filter #(
  parameter logic signed [7:0] K0 = 8'sd1,
  parameter logic signed [7:0] K1 = 8'sd2,
  parameter logic signed [7:0] K2 = 8'sd1,
  parameter logic signed [7:0] K3 = 8'sd2,
  parameter logic signed [7:0] K4 = 8'sd4,
  parameter logic signed [7:0] K5 = 8'sd2,
  parameter logic signed [7:0] K6 = 8'sd1,
  parameter logic signed [7:0] K7 = 8'sd2,
  parameter logic signed [7:0] K8 = 8'sd1,
  parameter int SHIFT = 4,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] pixelr1,
  input  logic [7:0] pixelr2,
  input  logic [7:0] pixelr3,
  input  logic [7:0] pixelr4,
  input  logic [7:0] pixelr5,
  input  logic [7:0] pixelr6,
  input  logic [7:0] pixelr7,
  input  logic [7:0] pixelr8,
  input  logic [7:0] pixelr9,
  output logic [7:0] pixelw,
  output logic       wr,
  output logic       busy,
  output logic       done
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic accept;
  logic cnt_clr;
  logic pipe_busy;

  logic [7:0] pix [9];
  logic signed [7:0] kern [9];

  assign pix[0] = pixelr1;
  assign pix[1] = pixelr2;
  assign pix[2] = pixelr3;
  assign pix[3] = pixelr4;
  assign pix[4] = pixelr5;
  assign pix[5] = pixelr6;
  assign pix[6] = pixelr7;
  assign pix[7] = pixelr8;
  assign pix[8] = pixelr9;

  assign kern[0] = K0;
  assign kern[1] = K1;
  assign kern[2] = K2;
  assign kern[3] = K3;
  assign kern[4] = K4;
  assign kern[5] = K5;
  assign kern[6] = K6;
  assign kern[7] = K7;
  assign kern[8] = K8;

  // Pipeline registers with their valid bits
  logic signed [16:0] prod [9];
  logic signed [18:0] row_sum [3];
  logic signed [20:0] total_c;
  logic signed [20:0] scaled;
  logic [7:0] sat;
  logic v1, v2, v3, v4;

  // --------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    cnt_clr  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = RUN;
          cnt_clr  = 1'b1;
        end
      end
      RUN: begin
        if (in_valid) begin
          accept = 1'b1;
          // Leave RUN on the same edge the final window is captured.
          if (cnt == CNT_LAST) begin
            state_nx = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Output register is excluded, so DONE lands one cycle after
        // the final wr pulse.
        if (!pipe_busy) begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pipe_busy = v1 | v2 | v3 | v4;
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // --------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------
  // Stage 1: pixel * coefficient, pixel zero-extended to stay unsigned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        prod[i] <= '0;
      end
    end else begin
      v1 <= accept;
      for (int i = 0; i < 9; i++) begin
        prod[i] <= 17'(signed'({1'b0, pix[i]})) * 17'(kern[i]);
      end
    end
  end

  // Stage 2: one sum per kernel row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        row_sum[r] <= '0;
      end
    end else begin
      v2 <= v1;
      for (int r = 0; r < 3; r++) begin
        row_sum[r] <= 19'(prod[3*r]) + 19'(prod[3*r+1]) + 19'(prod[3*r+2]);
      end
    end
  end

  // Stage 3: total and normalisation; >>> floors toward -infinity.
  assign total_c = 21'(row_sum[0]) + 21'(row_sum[1]) + 21'(row_sum[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3     <= 1'b0;
      scaled <= '0;
    end else begin
      v3     <= v2;
      scaled <= total_c >>> SHIFT;
    end
  end

  // Stage 4: clamp to 0..255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4  <= 1'b0;
      sat <= '0;
    end else begin
      v4 <= v3;
      if (scaled[20]) begin
        sat <= 8'h00;
      end else if (scaled > 21'sd255) begin
        sat <= 8'hFF;
      end else begin
        sat <= scaled[7:0];
      end
    end
  end

  // Output register; pixelw is forced to zero between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr     <= 1'b0;
      pixelw <= 8'h00;
    end else begin
      wr     <= v4;
      pixelw <= v4 ? sat : 8'h00;
    end
  end

endmodule

// File: tb/tb_conv3x3_filter.sv
// Testbench for conv3x3_filter. Five instances with different kernels share
// one stimulus stream; a transaction-level model predicts when each write
// appears and what each instance should output.
module tb_conv3x3_filter;

  typedef logic [8:0][7:0] win_t;   // index i carries pixelr(i+1)
  typedef logic [4:0][7:0] res_t;   // index u is the result of instance u

  typedef struct packed {
    logic [31:0] due;
    res_t        exp;
  } item_t;

  typedef struct packed {
    win_t pix;
    res_t exp;
  } vec_t;

  localparam int TOTAL   = 16;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic in_valid;
  win_t px;
  res_t pw;
  logic [4:0] wr_o;
  logic [4:0] busy_o;
  logic [4:0] done_o;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int ph = M_IDLE;
  int acc_cnt = 0;
  int last_due = 0;
  int wr_cnt = 0;
  item_t q[$];
  vec_t tbl [8];

  // u0: default smoothing kernel, SHIFT 4
  conv3x3_filter #(.IMG_W(4), .IMG_H(4)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .pixelr1(px[0]), .pixelr2(px[1]), .pixelr3(px[2]), .pixelr4(px[3]),
    .pixelr5(px[4]), .pixelr6(px[5]), .pixelr7(px[6]), .pixelr8(px[7]),
    .pixelr9(px[8]), .pixelw(pw[0]), .wr(wr_o[0]), .busy(busy_o[0]),
    .done(done_o[0]));

  // u1: all ones, no shift
  conv3x3_filter #(.K0(8'sd1), .K1(8'sd1), .K2(8'sd1), .K3(8'sd1), .K4(8'sd1),
                   .K5(8'sd1), .K6(8'sd1), .K7(8'sd1), .K8(8'sd1),
                   .SHIFT(0), .IMG_W(4), .IMG_H(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .pixelr1(px[0]), .pixelr2(px[1]), .pixelr3(px[2]), .pixelr4(px[3]),
    .pixelr5(px[4]), .pixelr6(px[5]), .pixelr7(px[6]), .pixelr8(px[7]),
    .pixelr9(px[8]), .pixelw(pw[1]), .wr(wr_o[1]), .busy(busy_o[1]),
    .done(done_o[1]));

  // u2: laplacian-like, centre -8
  conv3x3_filter #(.K0(8'sd1), .K1(8'sd1), .K2(8'sd1), .K3(8'sd1), .K4(-8'sd8),
                   .K5(8'sd1), .K6(8'sd1), .K7(8'sd1), .K8(8'sd1),
                   .SHIFT(0), .IMG_W(4), .IMG_H(4)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .pixelr1(px[0]), .pixelr2(px[1]), .pixelr3(px[2]), .pixelr4(px[3]),
    .pixelr5(px[4]), .pixelr6(px[5]), .pixelr7(px[6]), .pixelr8(px[7]),
    .pixelr9(px[8]), .pixelw(pw[2]), .wr(wr_o[2]), .busy(busy_o[2]),
    .done(done_o[2]));

  // u3: centre -1 only, SHIFT 1
  conv3x3_filter #(.K0(8'sd0), .K1(8'sd0), .K2(8'sd0), .K3(8'sd0), .K4(-8'sd1),
                   .K5(8'sd0), .K6(8'sd0), .K7(8'sd0), .K8(8'sd0),
                   .SHIFT(1), .IMG_W(4), .IMG_H(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .pixelr1(px[0]), .pixelr2(px[1]), .pixelr3(px[2]), .pixelr4(px[3]),
    .pixelr5(px[4]), .pixelr6(px[5]), .pixelr7(px[6]), .pixelr8(px[7]),
    .pixelr9(px[8]), .pixelw(pw[3]), .wr(wr_o[3]), .busy(busy_o[3]),
    .done(done_o[3]));

  // u4: centre +1 only, SHIFT 1
  conv3x3_filter #(.K0(8'sd0), .K1(8'sd0), .K2(8'sd0), .K3(8'sd0), .K4(8'sd1),
                   .K5(8'sd0), .K6(8'sd0), .K7(8'sd0), .K8(8'sd0),
                   .SHIFT(1), .IMG_W(4), .IMG_H(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .pixelr1(px[0]), .pixelr2(px[1]), .pixelr3(px[2]), .pixelr4(px[3]),
    .pixelr5(px[4]), .pixelr6(px[5]), .pixelr7(px[6]), .pixelr8(px[7]),
    .pixelr9(px[8]), .pixelw(pw[4]), .wr(wr_o[4]), .busy(busy_o[4]),
    .done(done_o[4]));

  // Reference: exact integer sum, floor division by 2^SHIFT, clamp.
  function automatic int ref_out(input int u, input win_t w);
    int k[9];
    int sh;
    int sum;
    int d;
    int qv;
    case (u)
      0:       begin k = '{1, 2, 1, 2, 4, 2, 1, 2, 1}; sh = 4; end
      1:       begin k = '{1, 1, 1, 1, 1, 1, 1, 1, 1}; sh = 0; end
      2:       begin k = '{1, 1, 1, 1, -8, 1, 1, 1, 1}; sh = 0; end
      3:       begin k = '{0, 0, 0, 0, -1, 0, 0, 0, 0}; sh = 1; end
      default: begin k = '{0, 0, 0, 0, 1, 0, 0, 0, 0}; sh = 1; end
    endcase
    sum = 0;
    for (int i = 0; i < 9; i++) sum += int'(w[i]) * k[i];
    d = 1 << sh;
    if (sum >= 0) qv = sum / d;
    else qv = -((-sum + d - 1) / d);
    if (qv < 0) return 0;
    if (qv > 255) return 255;
    return qv;
  endfunction

  function automatic res_t model_res(input win_t w);
    res_t r;
    for (int u = 0; u < 5; u++) r[u] = 8'(ref_out(u, w));
    return r;
  endfunction

  function automatic win_t win9(input int p1, input int p2, input int p3,
                                input int p4, input int p5, input int p6,
                                input int p7, input int p8, input int p9);
    win_t w;
    w[0] = 8'(p1); w[1] = 8'(p2); w[2] = 8'(p3);
    w[3] = 8'(p4); w[4] = 8'(p5); w[5] = 8'(p6);
    w[6] = 8'(p7); w[7] = 8'(p8); w[8] = 8'(p9);
    return w;
  endfunction

  function automatic res_t res5(input int e0, input int e1, input int e2,
                                input int e3, input int e4);
    res_t r;
    r[0] = 8'(e0); r[1] = 8'(e1); r[2] = 8'(e2); r[3] = 8'(e3); r[4] = 8'(e4);
    return r;
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int u = 0; u < 5; u++) begin
      chk($sformatf("%s_wr[%0d]", tag, u), int'(wr_o[u]), 0);
      chk($sformatf("%s_pixelw[%0d]", tag, u), int'(pw[u]), 0);
      chk($sformatf("%s_busy[%0d]", tag, u), int'(busy_o[u]), 0);
      chk($sformatf("%s_done[%0d]", tag, u), int'(done_o[u]), 0);
    end
  endtask

  // One clock: drive, clock, advance the model, compare every instance.
  task automatic step(input logic s, input logic v, input win_t w,
                      input logic use_tbl, input res_t texp);
    item_t it;
    logic  exp_wr;
    res_t  e;
    int    exp_busy;
    int    exp_done;
    start    = s;
    in_valid = v;
    px       = w;
    @(posedge clk);
    ecount++;
    #1;
    if (ph == M_RUN && v) begin
      it.due = 32'(ecount + 4);
      it.exp = use_tbl ? texp : model_res(w);
      q.push_back(it);
      acc_cnt++;
      if (acc_cnt == TOTAL) begin
        ph = M_DRAIN;
        last_due = ecount + 4;
      end
    end else if ((ph == M_IDLE || ph == M_DONE) && s) begin
      ph = M_RUN;
      acc_cnt = 0;
    end else if (ph == M_DRAIN && ecount == last_due + 1) begin
      ph = M_DONE;
    end
    exp_wr = 1'b0;
    e = '0;
    if (q.size() > 0 && int'(q[0].due) == ecount) begin
      it = q.pop_front();
      exp_wr = 1'b1;
      e = it.exp;
    end
    exp_busy = (ph == M_RUN || ph == M_DRAIN) ? 1 : 0;
    exp_done = (ph == M_DONE) ? 1 : 0;
    if (wr_o[0]) wr_cnt++;
    for (int u = 0; u < 5; u++) begin
      chk($sformatf("wr[%0d]@%0d", u, ecount), int'(wr_o[u]), int'(exp_wr));
      chk($sformatf("pixelw[%0d]@%0d", u, ecount), int'(pw[u]), int'(e[u]));
      chk($sformatf("busy[%0d]@%0d", u, ecount), int'(busy_o[u]), exp_busy);
      chk($sformatf("done[%0d]@%0d", u, ecount), int'(done_o[u]), exp_done);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && ph != M_DONE; i++) idle();
    chk({tag, "_done_reached"}, int'(done_o[0]), 1);
    chk({tag, "_wr_count"}, wr_cnt, TOTAL);
    idle();
    idle();
  endtask

  initial begin
    tbl[0].pix = win9(100, 100, 100, 100, 100, 100, 100, 100, 100);
    tbl[0].exp = res5(100, 255, 0, 0, 50);
    tbl[1].pix = win9(255, 255, 255, 255, 255, 255, 255, 255, 255);
    tbl[1].exp = res5(255, 255, 0, 0, 127);
    tbl[2].pix = win9(0, 0, 0, 0, 255, 0, 0, 0, 0);
    tbl[2].exp = res5(63, 255, 0, 0, 127);
    tbl[3].pix = win9(0, 0, 0, 0, 3, 0, 0, 0, 0);
    tbl[3].exp = res5(0, 3, 0, 0, 1);
    tbl[4].pix = win9(255, 255, 255, 255, 0, 255, 255, 255, 255);
    tbl[4].exp = res5(191, 255, 255, 0, 0);
    tbl[5].pix = win9(10, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[5].exp = res5(0, 10, 10, 0, 0);
    tbl[6].pix = win9(1, 2, 3, 4, 5, 6, 7, 8, 9);
    tbl[6].exp = res5(5, 45, 0, 0, 2);
    tbl[7].pix = win9(20, 20, 20, 20, 200, 20, 20, 20, 20);
    tbl[7].exp = res5(65, 255, 0, 0, 100);

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    px       = '0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();

    // Frame A: table vectors back-to-back, in_valid also high on the start
    // edge, and kept high 5 cycles past the end of the frame.
    wr_cnt = 0;
    step(1'b1, 1'b1, tbl[3].pix, 1'b1, tbl[3].exp);
    for (int i = 0; i < TOTAL + 5; i++)
      step(1'b0, 1'b1, tbl[i % 8].pix, 1'b1, tbl[i % 8].exp);
    wait_done("frameA");

    // Frame B: flat image restarted from DONE, valid every third cycle.
    wr_cnt = 0;
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3 * TOTAL; i++)
      step(1'b0, (i % 3) == 0, tbl[0].pix, 1'b1, tbl[0].exp);
    wait_done("frameB");

    // Frame C: random windows with random gaps.
    wr_cnt = 0;
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 200 && ph == M_RUN; i++)
      step(1'b0, $urandom_range(0, 3) != 0, rand_win(), 1'b0, '0);
    wait_done("frameC");

    // Mid-frame asynchronous reset after 7 accepted windows.
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 20 && acc_cnt < 7; i++)
      step(1'b0, 1'b1, rand_win(), 1'b0, '0);
    chk("midreset_accepted", acc_cnt, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    q.delete();
    ph = M_IDLE;
    acc_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, rand_win(), 1'b0, '0);

    // Frame D after reset: random windows back-to-back.
    wr_cnt = 0;
    step(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 40 && ph == M_RUN; i++)
      step(1'b0, 1'b1, rand_win(), 1'b0, '0);
    wait_done("frameD");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv3x3_filter.md
# conv3x3_filter

Pipelined 3x3 convolution stage that sits directly downstream of the 3x3 window fetch memory. It consumes the nine window pixels (pixelr1..pixelr9, row-major, top-left first), applies a parameterised signed integer kernel, then normalises and saturates the result to 8 bits. It drives the write side of the result memory (pixelw plus its write strobe) and counts one full frame of outputs, so it doubles as the frame-completion controller.

## Interface
- K0..K8, default 1,2,1,2,4,2,1,2,1: signed 8-bit kernel coefficients, row-major; K0 multiplies pixelr1.
- SHIFT, default 4: arithmetic right-shift applied to the sum (normalisation).
- IMG_W, default 256: output pixels per row.
- IMG_H, default 256: output rows per frame.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; arms a new frame from IDLE or DONE.
- in_valid  in  1  the window on pixelr1..9 is valid this cycle. This is the fetch stage's rd delayed by one cycle.
- pixelr1..pixelr9  in  8 each  unsigned window pixels.
- pixelw  out  8  filtered pixel.
- wr  out  1  write strobe for pixelw.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- IDLE or DONE, start=1 -> RUN. The transition clears the frame counter, and done falls on the next cycle.
- RUN: every in_valid=1 cycle injects one window into the pipeline and increments the frame counter (width ceil(log2(IMG_W*IMG_H+1))).
  - On the cycle the counter reaches IMG_W*IMG_H, the FSM goes to DRAIN.
- DRAIN: wait until the pipeline is empty (no valid bit set in any stage), then go to DONE.
- in_valid is ignored in IDLE, DRAIN and DONE. Nothing enters the pipeline and the counter does not change.
- start is ignored in RUN and DRAIN.
- Datapath:
  - Stage 1: nine products p_k = {0,pixel} × K, each 17-bit signed.
  - Stage 2: three row sums, 19-bit signed.
  - Stage 3: total, 21-bit signed, then arithmetic shift right by SHIFT. This truncates toward −infinity.
  - Stage 4: saturate. A result below 0 gives 0; above 255 gives 255; otherwise its low 8 bits.
  - pixelw and wr are registered outputs of stage 4.
- A valid bit travels alongside each window. wr equals the stage-4 valid bit.
- pixelw is 8'h00 whenever wr=0.
- Back-to-back in_valid gives one output per cycle. There are no bubbles and no stalls; the block has no backpressure.
- Reset asserted mid-frame: all pipeline valid bits, the counter and the outputs clear immediately, and the FSM returns to IDLE. No partial write is emitted after reset releases.

## Timing
- Reset values: pixelw=0, wr=0, busy=0, done=0, state IDLE, counter 0, all stage valid bits 0.
- Latency: a window with in_valid at edge N appears as wr=1 with its pixelw after edge N+4.
- busy rises the cycle after the start edge and falls when DONE is entered.
- done rises on the same edge busy falls, which is also the edge of the final wr+1. done stays high until the next start or reset.
- The last output's wr=1 cycle precedes done=1 by exactly one cycle.
- The frame counter reaching IMG_W*IMG_H and the last window's entry into stage 1 happen on the same edge.
- in_valid in the cycle start is sampled is ignored; the first accepted window is on the edge after.
- Exactly IMG_W*IMG_H wr pulses occur per frame, even if in_valid stays high past frame end.

## Test plan
- Flat image: default kernel, all pixels 100, IMG_W=IMG_H=4.
  - Expect 16 wr pulses, each pixelw=100 (1600/16).
  - done=1 one cycle after the 16th wr.
- Saturation high: K all 1, SHIFT=0, all pixels 255.
  - Expect pixelw=255 (sum 2295 clamped).
  - Change to K4=−8, others 1, centre 255, neighbours 0: expect pixelw=0 (sum −2040 clamped).
- Negative truncation: K4=−1, others 0, SHIFT=1, centre 3.
  - Sum −3 >>> 1 = −2; expect pixelw=0.
  - Then K4=1, centre 3: expect pixelw=1.
- Latency and throughput: in_valid held high for 16 cycles from edge 10.
  - Expect wr=1 on edges 14..29 and zero bubbles.
  - Then a gapped pattern (valid every 3rd cycle): wr follows the same gaps, shifted by 4.
- Over-supply and restart: keep in_valid high 5 cycles past frame end.
  - Expect no extra wr, and the counter holds.
  - start in DONE clears done and runs a second identical frame.
- Mid-frame reset: assert rst_n=0 asynchronously after 7 accepted windows.
  - All outputs must be 0 immediately and the FSM in IDLE.
  - After release, no wr appears until start plus new windows arrive.
